video_timing_gen: RTL



---
 rtl/video_timing_gen_pkg.sv | 42 ++++
 rtl/video_timing_gen_if.sv | 26 ++
 rtl/video_timing_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/video_timing_gen_pkg.sv
// Raster timing constant sets shared by generator instantiations and benches.
package video_timing_pkg;

    // One complete raster description: active/porch/sync lengths and sync polarity.
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } timing_cfg_t;

    // CEA 1280x720p60, 74.25 MHz pixel clock, positive syncs.
    localparam timing_cfg_t CFG_720P60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        hs_pol: 1'b1,   vs_pol: 1'b1
    };

    // VGA 640x480p60, 25.175 MHz pixel clock, negative syncs.
    localparam timing_cfg_t CFG_480P60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol: 1'b0,  vs_pol: 1'b0
    };

    // Clocks per line for a configuration.
    function automatic int unsigned h_total(input timing_cfg_t cfg);
        return cfg.h_active + cfg.h_fp + cfg.h_sync + cfg.h_bp;
    endfunction

    // Lines per frame for a configuration.
    function automatic int unsigned v_total(input timing_cfg_t cfg);
        return cfg.v_active + cfg.v_fp + cfg.v_sync + cfg.v_bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle between the timing generator and the pixel pipeline.
interface video_timing_gen_if #(
    parameter int unsigned X_W = 11,
    parameter int unsigned Y_W = 10
);
    logic           en;
    logic           tx_dv;
    logic           tx_hs;
    logic           tx_vs;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;

    // Generator side: takes run enable, produces timing.
    modport master (
        input  en,
        output tx_dv, tx_hs, tx_vs, x, y, line_start, frame_start
    );

    // Consumer side: drives run enable, receives timing.
    modport slave (
        output en,
        input  tx_dv, tx_hs, tx_vs, x, y, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters plus a registered decoder for dv/syncs/coords/strobes.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = CFG_720P60.h_active,
    parameter int unsigned H_FP     = CFG_720P60.h_fp,
    parameter int unsigned H_SYNC   = CFG_720P60.h_sync,
    parameter int unsigned H_BP     = CFG_720P60.h_bp,
    parameter int unsigned V_ACTIVE = CFG_720P60.v_active,
    parameter int unsigned V_FP     = CFG_720P60.v_fp,
    parameter int unsigned V_SYNC   = CFG_720P60.v_sync,
    parameter int unsigned V_BP     = CFG_720P60.v_bp,
    parameter bit          HS_POL   = CFG_720P60.hs_pol,
    parameter bit          VS_POL   = CFG_720P60.vs_pol,
    parameter int unsigned X_W      = 11,
    parameter int unsigned Y_W      = 10
) (
    input  logic              tx_clk,
    input  logic              rst,
    video_timing_gen_if.master vif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W    = $clog2(H_TOTAL);
    localparam int unsigned VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_AEND  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_AEND  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reject configurations the counters and coordinate outputs cannot represent.
    generate
        if (int'(X_W) < $clog2(H_ACTIVE) || int'(Y_W) < $clog2(V_ACTIVE)) begin : g_bad_coord_w
            $error("video_timing_gen: X_W/Y_W too narrow for active area");
        end
        if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
            $error("video_timing_gen: porch and sync lengths must be at least 1");
        end
    endgenerate

    logic [HC_W-1:0] h_cnt_q, h_cnt_d;
    logic [VC_W-1:0] v_cnt_q, v_cnt_d;
    logic            dv_q, dv_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            ls_q, ls_d;
    logic            fs_q, fs_d;
    logic            active;

    // Decode the current counter position and compute the next counter position.
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        dv_d    = 1'b0;
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        x_d     = '0;
        y_d     = '0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        active  = (h_cnt_q < H_AEND) && (v_cnt_q < V_AEND);

        if (vif.en) begin
            dv_d = active;
            hs_d = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
            vs_d = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
            x_d  = active ? X_W'(h_cnt_q) : x_q;
            y_d  = active ? Y_W'(v_cnt_q) : y_q;
            ls_d = active && (h_cnt_q == '0);
            fs_d = active && (h_cnt_q == '0) && (v_cnt_q == '0);

            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VC_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + HC_W'(1);
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Counter and output registers; reset parks the raster at its origin with syncs idle.
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            dv_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            dv_q    <= dv_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign vif.tx_dv       = dv_q;
    assign vif.tx_hs       = hs_q;
    assign vif.tx_vs       = vs_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = ls_q;
    assign vif.frame_start = fs_q;

endmodule
